// File: rtl/lockable_reg_bank_pkg.sv
// Shared types and default sizes for the lockable register bank.
package lockable_reg_bank_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_DBG_QUAL = 4;

  typedef enum logic [1:0] {
    DBG_OFF,
    DBG_QUAL,
    DBG_ON
  } dbg_state_e;

endpackage

// File: rtl/lockable_dbg_qual.sv
// Debug override qualifier: debug_unlocked must stay high for DBG_QUAL cycles
// after entering qualification before Dbg_active asserts; any low cycle aborts.
module lockable_dbg_qual #(
  parameter int DBG_QUAL = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic debug_unlocked,
  output logic Dbg_active
);

  localparam int QCNT_W = (DBG_QUAL > 1) ? $clog2(DBG_QUAL) : 1;
  localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(DBG_QUAL - 1);

  lockable_reg_bank_pkg::dbg_state_e state_q, state_d;
  logic [QCNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= lockable_reg_bank_pkg::DBG_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The entry edge into DBG_QUAL is not counted, so DBG_ON arrives DBG_QUAL+1 edges after the request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    Dbg_active = (state_q == lockable_reg_bank_pkg::DBG_ON);
    if (!debug_unlocked) begin
      state_d = lockable_reg_bank_pkg::DBG_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        lockable_reg_bank_pkg::DBG_OFF: begin
          state_d = lockable_reg_bank_pkg::DBG_QUAL;
          cnt_d   = '0;
        end
        lockable_reg_bank_pkg::DBG_QUAL: begin
          if (cnt_q == QCNT_LAST) begin
            state_d = lockable_reg_bank_pkg::DBG_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        lockable_reg_bank_pkg::DBG_ON: state_d = lockable_reg_bank_pkg::DBG_ON;
        default: begin
          state_d = lockable_reg_bank_pkg::DBG_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lockable_reg_bank.sv
// Bank of registers with sticky per-register locks and write-violation reporting.
// Define LOCKABLE_REG_BANK_DEBUG_OVERRIDE_EN to build the qualified debug override.
module lockable_reg_bank
  import lockable_reg_bank_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                NUM_REGS  = DEF_NUM_REGS,
  parameter int                ADDR_W    = $clog2(NUM_REGS),
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                DBG_QUAL  = DEF_DBG_QUAL,
  parameter int                CNT_W     = DEF_CNT_W
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic                write,
  input  logic [DATA_W-1:0]   Data_in,
  input  logic                Lock,
  input  logic [NUM_REGS-1:0] Lock_mask,
  input  logic                debug_unlocked,
  output logic [DATA_W-1:0]   Data_out,
  output logic [NUM_REGS-1:0] Lock_status,
  output logic                Wr_err,
  output logic [CNT_W-1:0]    Viol_cnt,
  output logic                Dbg_active
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] addr_hit;
  logic [NUM_REGS-1:0] eff_lock;
  logic [DATA_W-1:0]   rd_data;
  logic                in_range;
  logic                permitted;
  logic                wr_ok;
  logic                wr_viol;
  logic                dbg_active;

`ifdef LOCKABLE_REG_BANK_DEBUG_OVERRIDE_EN
  lockable_dbg_qual #(
    .DBG_QUAL(DBG_QUAL)
  ) u_dbg_qual (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .debug_unlocked(debug_unlocked),
    .Dbg_active    (dbg_active)
  );
`else
  localparam int dbg_qual_unused = DBG_QUAL;
  logic debug_unlocked_unused;
  assign debug_unlocked_unused = debug_unlocked;
  assign dbg_active            = 1'b0;
`endif

  assign Dbg_active = dbg_active;

  // One-hot decode; an out-of-range address hits nothing, so it reads 0 and cannot write.
  always_comb begin
    addr_hit = '0;
    rd_data  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      addr_hit[i] = (Addr == ADDR_W'(i));
      if (addr_hit[i]) rd_data = regs[i];
    end
  end

  // A lock strobed this cycle already counts, so it blocks a same-cycle write.
  assign eff_lock  = Lock_status | (Lock_mask & {NUM_REGS{Lock}});
  assign in_range  = |addr_hit;
  assign permitted = ~(|(addr_hit & eff_lock)) | dbg_active;
  assign wr_ok     = write & in_range & permitted;
  assign wr_viol   = write & ~wr_ok;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && addr_hit[i]) regs[i] <= Data_in;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Lock_status <= '0;
      Data_out    <= '0;
      Wr_err      <= 1'b0;
      Viol_cnt    <= '0;
    end else begin
      Lock_status <= eff_lock;
      Data_out    <= rd_data;
      Wr_err      <= wr_viol;
      if (wr_viol && (Viol_cnt != {CNT_W{1'b1}})) Viol_cnt <= Viol_cnt + 1'b1;
    end
  end

endmodule

// File: doc/lockable_reg_bank.md
# lockable_reg_bank

Parametrised bank of NUM_REGS lockable data registers with per-register sticky lock bits, a qualified debug override, and write-violation reporting. It replaces single-register lock/data pairs in security-sensitive configuration paths. Every state element is reset, and a lock can only be cleared by reset. Blocked writes are reported and counted.

## Interface
Parameters:
- DATA_W, 16, register data width
- NUM_REGS, 4, number of registers (≥2)
- ADDR_W, $clog2(NUM_REGS), address width
- RESET_VAL, '0, reset value of every data register
- DBG_QUAL, 4, consecutive cycles debug_unlocked must be high before override is active (≥1)
- CNT_W, 8, violation counter width

Ports (one clock; reset is asynchronous and active-low):
- Clk  in  1  clock, rising edge
- Rst_n  in  1  async active-low reset
- Addr  in  ADDR_W  register select for write and read
- write  in  1  write strobe
- Data_in  in  DATA_W  write data
- Lock  in  1  lock strobe, applies to the registers set in Lock_mask
- Lock_mask  in  NUM_REGS  registers to lock when Lock=1
- debug_unlocked  in  1  debug override request (raw, unqualified)
- Data_out  out  DATA_W  registered read data of the register selected by Addr
- Lock_status  out  NUM_REGS  current lock bits
- Wr_err  out  1  one-cycle pulse, previous write rejected
- Viol_cnt  out  CNT_W  saturating count of rejected writes
- Dbg_active  out  1  qualified debug override in effect

## Operation
- Reset values: all data registers = RESET_VAL, Lock_status=0, Data_out=0, Wr_err=0, Viol_cnt=0, Dbg_active=0, debug FSM in DBG_OFF.
- Lock: when Lock=1, set lock[i] for every i with Lock_mask[i]=1. Locks are sticky and cleared only by Rst_n.
- Write permission for register Addr: permitted = ~(lock[Addr] | (Lock & Lock_mask[Addr])) | Dbg_active. A lock requested in the same cycle blocks that cycle's write.
- Write with Addr < NUM_REGS and permitted: register updated at the edge. Otherwise the register is unchanged, Wr_err=1 on the next cycle, and Viol_cnt increments, saturating at all-ones.
- An out-of-range Addr (non-power-of-2 NUM_REGS) on a write counts as a violation. On a read it returns 0.
- Read: Data_out <= reg[Addr] every cycle. Read data reflects register contents before any write in the same cycle, i.e. no write-through.
- Debug FSM:
  - DBG_OFF → DBG_QUAL when debug_unlocked=1.
  - DBG_QUAL counts cycles with debug_unlocked held high. After DBG_QUAL consecutive cycles it moves to DBG_ON.
  - Any cycle with debug_unlocked=0 returns the FSM to DBG_OFF and clears the count, from either state.
  - Dbg_active=1 only in DBG_ON.
- The debug override never clears lock bits. It only bypasses them while active.

## Timing
- Write to register: 1 cycle. Data_out reflects a write 1 cycle after the write edge when Addr is held.
- Read latency: 1 cycle.
- Wr_err: asserted the cycle after the rejected write, for exactly 1 cycle per rejected write. Back-to-back rejected writes keep it high.
- Lock_status: updates at the edge where Lock is sampled.
- Dbg_active: rises DBG_QUAL+1 edges after debug_unlocked rises (OFF→QUAL, then DBG_QUAL counts). It falls on the first edge after debug_unlocked falls.
- Rst_n assertion mid-operation: all state returns to reset values immediately. Writes in flight are lost.

## Configuration
- LOCKABLE_REG_BANK_DEBUG_OVERRIDE_EN
  - Defined: debug FSM present, with override as above.
  - Undefined: FSM not built, Dbg_active tied 0, and debug_unlocked is ignored. Locked registers are then unwritable until reset. This is the production build.

## Structure
- Package lockable_reg_bank_pkg holds:
  - dbg_state_e enum (DBG_OFF, DBG_QUAL, DBG_ON)
  - default DATA_W/NUM_REGS/CNT_W constants
- Sub-module lockable_dbg_qual: the debug qualification FSM and counter (inputs Clk, Rst_n, debug_unlocked; output Dbg_active; parameter DBG_QUAL). It is instantiated only under the macro.

## Test plan
- Reset then read all addresses → Data_out = RESET_VAL each, Lock_status=0, Viol_cnt=0.
- Write 16'hA5A5 to reg 1, Lock with mask 4'b0010, write 16'h1234 to reg 1 → reg 1 reads 16'hA5A5, Wr_err pulses once, Viol_cnt=1. A write to reg 2 still succeeds.
- Lock and write reg 0 in the same cycle → write blocked, lock[0]=1, Viol_cnt+1.
- Macro on, reg 3 locked:
  - debug_unlocked held for 3 cycles then dropped → Dbg_active stays 0, and a write is rejected.
  - debug_unlocked held ≥5 cycles → write 16'hBEEF to reg 3 succeeds, and Lock_status[3] stays 1.
- 260 rejected writes with CNT_W=8 → Viol_cnt saturates at 255.
- Assert Rst_n low mid-write with locks set → locks, data, counter and FSM return to reset values on the asynchronous edge.
